// File: rtl/fmul_pkg.sv
// Shared definitions for the FP multiplier writeback queue: datum/tag
// widths, exception flag bit positions and the issue tag layout.
package fmul_pkg;

    localparam int FMUL_EXP_W    = 5;
    localparam int FMUL_FRAC_W   = 3;
    localparam int FMUL_DATA_W   = FMUL_EXP_W + FMUL_FRAC_W + 1;
    localparam int FMUL_CTRL_C_W = 16;
    localparam int FMUL_WARP_W   = 4;
    localparam int FMUL_TAG_W    = FMUL_CTRL_C_W + 3 + 8 + FMUL_WARP_W;
    localparam int FMUL_QDEPTH   = 4;

    localparam int FLAG_OF = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NV = 2;

    typedef struct packed {
        logic [FMUL_CTRL_C_W-1:0] c;
        logic [2:0]               rm;
        logic [7:0]               reg_idxw;
        logic [FMUL_WARP_W-1:0]   warpid;
    } fmul_tag_t;

endpackage

// File: rtl/fmul_wb_ptr.sv
// Wrap-bit pointer counter: PW bits, MSB is the wrap bit, increments
// by one when inc_i is high. Ports: clk, rst_n, inc_i, ptr_o.
module fmul_wb_ptr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/fmul_wb_queue.sv
// Writeback reorder / tag-alignment queue behind the 3-stage FP multiplier.
// Captures the control tag at issue, pairs it with the in-order result and
// presents {result, fflags, tag} to writeback over valid/ready.
// Ports: issue side (issue_valid_i/issue_ready_o, ctrl_*_i), result side
// (res_valid_i, result_i, fflags_i), output side (out_valid_o/out_ready_i,
// out_*_o), err_o (sticky), fflags_acc_o / fflags_clr_i.
// Optional macro FMUL_WB_FFLAGS_ACC_EN builds the popped-flags accumulator.
module fmul_wb_queue
    import fmul_pkg::*;
#(
    parameter int EXP_WIDTH    = FMUL_EXP_W,
    parameter int FRAC_WIDTH   = FMUL_FRAC_W,
    parameter int CTRL_C_WIDTH = FMUL_CTRL_C_W,
    parameter int DEPTH_WARP   = FMUL_WARP_W,
    parameter int QDEPTH       = FMUL_QDEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              issue_valid_i,
    output logic                              issue_ready_o,
    input  logic [CTRL_C_WIDTH-1:0]           ctrl_c_i,
    input  logic [2:0]                        ctrl_rm_i,
    input  logic [7:0]                        ctrl_reg_idxw_i,
    input  logic [DEPTH_WARP-1:0]             ctrl_warpid_i,
    input  logic                              res_valid_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]     result_i,
    input  logic [4:0]                        fflags_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]     out_result_o,
    output logic [4:0]                        out_fflags_o,
    output logic [CTRL_C_WIDTH-1:0]           out_ctrl_c_o,
    output logic [2:0]                        out_ctrl_rm_o,
    output logic [7:0]                        out_ctrl_reg_idxw_o,
    output logic [DEPTH_WARP-1:0]             out_ctrl_warpid_o,
    output logic                              err_o,
    output logic [4:0]                        fflags_acc_o,
    input  logic                              fflags_clr_i
);

    localparam int DW = EXP_WIDTH + FRAC_WIDTH + 1;
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [CTRL_C_WIDTH-1:0] c;
        logic [2:0]              rm;
        logic [7:0]              reg_idxw;
        logic [DEPTH_WARP-1:0]   warpid;
    } tag_t;

    tag_t              r_tag   [QDEPTH];
    logic [DW-1:0]     r_res   [QDEPTH];
    logic [4:0]        r_flags [QDEPTH];
    logic [QDEPTH-1:0] r_done;
    logic              r_err;

    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_res_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic [PW-1:0] w_occ;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_res_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_issue_fire;
    logic          w_res_ok;
    logic          w_res_fire;
    logic          w_pop_fire;

    assign w_wr_idx  = w_wr_ptr[AW-1:0];
    assign w_res_idx = w_res_ptr[AW-1:0];
    assign w_rd_idx  = w_rd_ptr[AW-1:0];

    // Occupancy counts issued-but-not-popped ops, so a slot is reserved
    // for every in-flight multiply.
    assign w_occ         = w_wr_ptr - w_rd_ptr;
    assign issue_ready_o = (w_occ != PW'(QDEPTH));
    assign w_issue_fire  = issue_valid_i & issue_ready_o;

    // A result needs an outstanding tag; otherwise it is a protocol error.
    assign w_res_ok   = (w_res_ptr != w_wr_ptr);
    assign w_res_fire = res_valid_i & w_res_ok;

    assign out_valid_o = (w_rd_ptr != w_res_ptr) & r_done[w_rd_idx];
    assign w_pop_fire  = out_valid_o & out_ready_i;

    fmul_wb_ptr #(.PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_issue_fire),
        .ptr_o (w_wr_ptr)
    );

    fmul_wb_ptr #(.PW(PW)) u_res_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_res_fire),
        .ptr_o (w_res_ptr)
    );

    fmul_wb_ptr #(.PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_pop_fire),
        .ptr_o (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_tag[i]   <= '0;
                r_res[i]   <= '0;
                r_flags[i] <= '0;
            end
            r_done <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_issue_fire) begin
                r_tag[w_wr_idx]  <= {ctrl_c_i, ctrl_rm_i,
                                     ctrl_reg_idxw_i, ctrl_warpid_i};
                r_done[w_wr_idx] <= 1'b0;
            end
            // res_ptr != wr_ptr here, so never the entry being issued
            if (w_res_fire) begin
                r_res[w_res_idx]   <= result_i;
                r_flags[w_res_idx] <= fflags_i;
                r_done[w_res_idx]  <= 1'b1;
            end
            if (res_valid_i && !w_res_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o               = r_err;
    assign out_result_o        = r_res[w_rd_idx];
    assign out_fflags_o        = r_flags[w_rd_idx];
    assign out_ctrl_c_o        = r_tag[w_rd_idx].c;
    assign out_ctrl_rm_o       = r_tag[w_rd_idx].rm;
    assign out_ctrl_reg_idxw_o = r_tag[w_rd_idx].reg_idxw;
    assign out_ctrl_warpid_o   = r_tag[w_rd_idx].warpid;

`ifdef FMUL_WB_FFLAGS_ACC_EN
    logic [4:0] r_acc;

    // Clear first, then OR, so flags popped during a clear survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= (fflags_clr_i ? 5'd0 : r_acc)
                   | (w_pop_fire ? out_fflags_o : 5'd0);
        end
    end

    assign fflags_acc_o = r_acc;
`else
    logic w_unused_clr;

    assign w_unused_clr = fflags_clr_i;
    assign fflags_acc_o = 5'd0;
`endif

endmodule

// File: tb/tb_fmul_wb_queue.sv
// Scoreboard bench for fmul_wb_queue with a 3-cycle multiplier model.
// Build with +define+FMUL_WB_FFLAGS_ACC_EN to cover the flag accumulator.
module tb_fmul_wb_queue;

    typedef struct packed {
        logic [15:0] c;
        logic [2:0]  rm;
        logic [7:0]  idx;
        logic [3:0]  wid;
    } tag_t;

    typedef struct packed {
        logic [8:0] res;
        logic [4:0] fl;
        tag_t       tag;
    } exp_t;

    typedef struct packed {
        logic       v;
        logic [8:0] r;
        logic [4:0] f;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [15:0] ctrl_c_i;
    logic [2:0]  ctrl_rm_i;
    logic [7:0]  ctrl_reg_idxw_i;
    logic [3:0]  ctrl_warpid_i;
    logic        res_valid_i;
    logic [8:0]  result_i;
    logic [4:0]  fflags_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [8:0]  out_result_o;
    logic [4:0]  out_fflags_o;
    logic [15:0] out_ctrl_c_o;
    logic [2:0]  out_ctrl_rm_o;
    logic [7:0]  out_ctrl_reg_idxw_o;
    logic [3:0]  out_ctrl_warpid_o;
    logic        err_o;
    logic [4:0]  fflags_acc_o;
    logic        fflags_clr_i;

    always #5 clk = ~clk;

    fmul_wb_queue dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .issue_valid_i       (issue_valid_i),
        .issue_ready_o       (issue_ready_o),
        .ctrl_c_i            (ctrl_c_i),
        .ctrl_rm_i           (ctrl_rm_i),
        .ctrl_reg_idxw_i     (ctrl_reg_idxw_i),
        .ctrl_warpid_i       (ctrl_warpid_i),
        .res_valid_i         (res_valid_i),
        .result_i            (result_i),
        .fflags_i            (fflags_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_result_o        (out_result_o),
        .out_fflags_o        (out_fflags_o),
        .out_ctrl_c_o        (out_ctrl_c_o),
        .out_ctrl_rm_o       (out_ctrl_rm_o),
        .out_ctrl_reg_idxw_o (out_ctrl_reg_idxw_o),
        .out_ctrl_warpid_o   (out_ctrl_warpid_o),
        .err_o               (err_o),
        .fflags_acc_o        (fflags_acc_o),
        .fflags_clr_i        (fflags_clr_i)
    );

    tag_t tagq[$];
    exp_t expq[$];
    op_t  pipe[3];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_out = 0;
    logic [4:0] m_acc = 5'd0;
    logic prev_stall = 1'b0;
    exp_t prev_data;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic tag_t mk_tag(logic [15:0] c, logic [3:0] w);
        tag_t t;
        t.c   = c;
        t.rm  = c[2:0];
        t.idx = c[7:0] ^ 8'h5A;
        t.wid = w;
        return t;
    endfunction

    // One clock: drive issue/ready, feed the multiplier model, advance.
    task automatic cyc(input logic iv, input tag_t t, input logic [8:0] r,
                       input logic [4:0] f, input logic rdy,
                       output logic fired);
        exp_t e;
        issue_valid_i   = iv;
        ctrl_c_i        = t.c;
        ctrl_rm_i       = t.rm;
        ctrl_reg_idxw_i = t.idx;
        ctrl_warpid_i   = t.wid;
        out_ready_i     = rdy;
        res_valid_i     = pipe[2].v;
        result_i        = pipe[2].r;
        fflags_i        = pipe[2].f;
        #1;
        fired = iv & issue_ready_o;
        if (pipe[2].v && tagq.size() > 0) begin
            e.res = pipe[2].r;
            e.fl  = pipe[2].f;
            e.tag = tagq.pop_front();
            expq.push_back(e);
        end
        if (fired) tagq.push_back(t);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = {fired, r, f};
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0;
        res_valid_i   = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        logic f;
        cyc(1'b0, '0, 9'd0, 5'd0, rdy, f);
    endtask

    task automatic drain(input logic toggle);
        int i;
        for (i = 0; i < 80; i++) begin
            if (tagq.size() == 0 && expq.size() == 0 &&
                !pipe[0].v && !pipe[1].v && !pipe[2].v) break;
            idle(toggle ? i[0] : 1'b1);
        end
        chk("drain_empty", {29'd0, tagq.size() == 0, expq.size() == 0,
                            out_valid_o}, 3'b110);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall hold
    // and the accumulated-flags model.
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = {out_result_o, out_fflags_o, out_ctrl_c_o, out_ctrl_rm_o,
               out_ctrl_reg_idxw_o, out_ctrl_warpid_o};
        if (!rst_n) begin
            m_acc = 5'd0;
            prev_stall = 1'b0;
        end else begin
            chk("fflags_acc", fflags_acc_o, m_acc);
            if (prev_stall) begin
                chk("stall_valid", out_valid_o, 1);
                chk("stall_data", cur, prev_data);
            end
            if (fflags_clr_i) m_acc = 5'd0;
            if (out_valid_o && out_ready_i) begin
                n_out++;
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_out: got %0h expected none", cur);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", cur, e);
`ifdef FMUL_WB_FFLAGS_ACC_EN
                    m_acc = m_acc | e.fl;
`endif
                end
            end
            prev_stall = out_valid_o & ~out_ready_i;
            prev_data  = cur;
        end
    end

    initial begin
        logic f;
        int acc_n;
        int cnt;
        int n0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        rst_n = 1'b0;
        issue_valid_i = 0;
        ctrl_c_i = 0;
        ctrl_rm_i = 0;
        ctrl_reg_idxw_i = 0;
        ctrl_warpid_i = 0;
        res_valid_i = 0;
        result_i = 0;
        fflags_i = 0;
        out_ready_i = 0;
        fflags_clr_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_result", out_result_o, 0);
        chk("rst_acc", fflags_acc_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_issue_ready", issue_ready_o, 1);

        // single op, latency
        cyc(1'b1, mk_tag(16'hA5A5, 4'd3), 9'h080, 5'd0, 1'b0, f);
        chk("t1_fired", f, 1);
        idle(1'b0);
        idle(1'b0);
        chk("t1_not_early", out_valid_o, 0);
        idle(1'b0);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_c", out_ctrl_c_o, 16'hA5A5);
        chk("t1_result", out_result_o, 9'h080);
        idle(1'b1);
        chk("t1_popped", out_valid_o, 0);

        // fill to full, one pop frees a slot
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, mk_tag(16'h0100 + 16'(i), 4'(i)), 9'h010 + 9'(i),
                5'd0, 1'b0, f);
            chk("t2_fill", f, 1);
        end
        chk("t2_full", issue_ready_o, 0);
        cyc(1'b1, mk_tag(16'h0199, 4'd9), 9'h0AA, 5'd0, 1'b0, f);
        chk("t2_refused", f, 0);
        repeat (3) idle(1'b0);
        chk("t2_still_full", issue_ready_o, 0);
        idle(1'b1);
        chk("t2_ready_after_pop", issue_ready_o, 1);
        cyc(1'b1, mk_tag(16'h0105, 4'd5), 9'h015, 5'd0, 1'b0, f);
        chk("t2_fifth", f, 1);
        drain(1'b0);

        // back-to-back 1..8 with toggling ready
        n0 = n_out;
        acc_n = 0;
        cnt = 0;
        while (acc_n < 8 && cnt < 100) begin
            cyc(1'b1, mk_tag(16'(acc_n + 1), 4'(acc_n + 1)),
                9'(acc_n * 5 + 1), 5'(acc_n + 1), ~cnt[0], f);
            if (f) acc_n++;
            cnt++;
        end
        chk("t3_issued", acc_n, 8);
        drain(1'b1);
        chk("t3_count", n_out - n0, 8);

        // stray result
        res_valid_i = 1'b1;
        result_i = 9'h1FF;
        fflags_i = 5'd7;
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        chk("t4_err", err_o, 1);
        chk("t4_empty", out_valid_o, 0);
        repeat (3) idle(1'b1);
        chk("t4_err_sticky", err_o, 1);
        chk("t4_ready", issue_ready_o, 1);

        // flag accumulation
        fflags_clr_i = 1'b1;
        idle(1'b0);
        fflags_clr_i = 1'b0;
        chk("t5_cleared", fflags_acc_o, 0);
        cyc(1'b1, mk_tag(16'h5001, 4'd1), 9'h033, 5'b00001, 1'b1, f);
        cyc(1'b1, mk_tag(16'h5002, 4'd2), 9'h034, 5'b00100, 1'b1, f);
        drain(1'b0);
        idle(1'b1);
`ifdef FMUL_WB_FFLAGS_ACC_EN
        chk("t5_acc", fflags_acc_o, 5'b00101);
`else
        chk("t5_acc", fflags_acc_o, 5'b00000);
`endif
        fflags_clr_i = 1'b1;
        idle(1'b0);
        fflags_clr_i = 1'b0;
        chk("t5_clr", fflags_acc_o, 0);
        cyc(1'b1, mk_tag(16'h5003, 4'd3), 9'h035, 5'b10000, 1'b0, f);
        repeat (3) idle(1'b0);
        fflags_clr_i = 1'b1;
        idle(1'b1);
        fflags_clr_i = 1'b0;
`ifdef FMUL_WB_FFLAGS_ACC_EN
        chk("t5_clr_pop", fflags_acc_o, 5'b10000);
`else
        chk("t5_clr_pop", fflags_acc_o, 5'b00000);
`endif

        // reset with pending entries
        for (int i = 0; i < 3; i++)
            cyc(1'b1, mk_tag(16'h7000 + 16'(i), 4'(i)), 9'h050 + 9'(i),
                5'd0, 1'b0, f);
        repeat (4) idle(1'b0);
        chk("t6_pending", out_valid_o, 1);
        rst_n = 1'b0;
        tagq.delete();
        expq.delete();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        #2;
        chk("t6_valid", out_valid_o, 0);
        chk("t6_ready", issue_ready_o, 1);
        chk("t6_err", err_o, 0);
        chk("t6_ptrs", {dut.w_wr_ptr, dut.w_res_ptr, dut.w_rd_ptr}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = n_out;
        cyc(1'b1, mk_tag(16'hBEEF, 4'd7), 9'h0C3, 5'b00010, 1'b1, f);
        drain(1'b0);
        chk("t6_after_reset", n_out - n0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
